// File: rtl/exu_div_ctrl_if.sv
// exu_div_ctrl_if: request, writeback and divider-side signals of the
// divider front end. The slave modport is the controller. The master
// modport is its environment, meaning the EXU issue/writeback logic and
// the iterative divider.
interface exu_div_ctrl_if #(
  parameter int XLEN = 64
);
  // EXU request
  logic            io_In_Valid;
  logic            io_In_Ready;
  logic [1:0]      io_In_Op;
  logic            io_In_Word;
  logic [XLEN-1:0] io_In_Src1;
  logic [XLEN-1:0] io_In_Src2;
  logic [4:0]      io_In_Rd;
  logic            io_Flush;
  // Writeback
  logic            io_Out_Valid;
  logic            io_Out_Ready;
  logic [XLEN-1:0] io_Out_Data;
  logic [4:0]      io_Out_Rd;
  // Iterative divider
  logic            io_Div_Valid;
  logic            io_Div_Flush;
  logic            io_Div_Divw;
  logic [1:0]      io_Div_Signed;
  logic [XLEN-1:0] io_Div_Divdend;
  logic [XLEN-1:0] io_Div_Divisor;
  logic            io_Div_Ready;
  logic            io_Div_OutValid;
  logic [XLEN-1:0] io_Div_Quotient;
  logic [XLEN-1:0] io_Div_Remainder;

  modport slave (
    input  io_In_Valid, io_In_Op, io_In_Word, io_In_Src1, io_In_Src2, io_In_Rd,
           io_Flush, io_Out_Ready, io_Div_Ready, io_Div_OutValid,
           io_Div_Quotient, io_Div_Remainder,
    output io_In_Ready, io_Out_Valid, io_Out_Data, io_Out_Rd, io_Div_Valid,
           io_Div_Flush, io_Div_Divw, io_Div_Signed, io_Div_Divdend, io_Div_Divisor
  );

  modport master (
    output io_In_Valid, io_In_Op, io_In_Word, io_In_Src1, io_In_Src2, io_In_Rd,
           io_Flush, io_Out_Ready, io_Div_Ready, io_Div_OutValid,
           io_Div_Quotient, io_Div_Remainder,
    input  io_In_Ready, io_Out_Valid, io_Out_Data, io_Out_Rd, io_Div_Valid,
           io_Div_Flush, io_Div_Divw, io_Div_Signed, io_Div_Divdend, io_Div_Divisor
  );
endinterface

// File: rtl/exu_div_ctrl.sv
// exu_div_ctrl: execute-stage front end for the iterative 64-bit divider.
// It resolves divide-by-zero and signed overflow locally. Every other
// request goes to the divider, and the selected result is returned with W
// forms sign-extended.
// Optional feature: define EXU_DIV_REUSE_EN to keep the last divider result
// (quotient and remainder). A request with identical operands then
// completes without a divider pass.
module exu_div_ctrl #(
  parameter int XLEN = 64
) (
  input logic           clock,
  input logic           reset,
  exu_div_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  // W operands use the low word only; sign- or zero-extended by op signedness.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic word, input logic sgn);
    if (!word) return v;
    return {{(XLEN-32){sgn & v[31]}}, v[31:0]};
  endfunction

  state_e          state_q;
  logic            in_ready_q, out_valid_q;
  logic [XLEN-1:0] src1_q, src2_q, result_q;
  logic [4:0]      rd_q;
  logic            word_q, signed_q, rem_q;

  logic            in_signed, is_zero, is_ovf, special;
  logic [XLEN-1:0] a_ext, b_ext, special_res, div_res;
  logic            div_active;
  logic            reuse_hit;
  logic [XLEN-1:0] reuse_res;

  assign in_signed = ~io.io_In_Op[0];
  assign a_ext     = extend(io.io_In_Src1, io.io_In_Word, in_signed);
  assign b_ext     = extend(io.io_In_Src2, io.io_In_Word, in_signed);
  assign is_zero   = (b_ext == '0);
  assign is_ovf    = in_signed && (b_ext == '1) && (a_ext == (io.io_In_Word ? MIN_W : MIN_D));
  assign special   = is_zero | is_ovf;
  // x/0: quotient all ones, remainder = dividend. MIN/-1: quotient = dividend, remainder 0.
  assign special_res = is_zero ? (io.io_In_Op[1] ? a_ext : '1)
                               : (io.io_In_Op[1] ? '0 : a_ext);
  assign div_res   = extend(rem_q ? io.io_Div_Remainder : io.io_Div_Quotient, word_q, 1'b1);

  // Operands and mode reach the divider only while it works for us.
  assign div_active        = (state_q == S_REQ) || (state_q == S_WAIT);
  assign io.io_Div_Valid   = (state_q == S_REQ) && io.io_Div_Ready && !io.io_Flush;
  assign io.io_Div_Flush   = ((state_q == S_WAIT) && io.io_Flush) ||
                             ((state_q == S_DRAIN) && !io.io_Div_Ready);
  assign io.io_Div_Divw    = div_active & word_q;
  assign io.io_Div_Signed  = {2{div_active & signed_q}};
  assign io.io_Div_Divdend = div_active ? src1_q : '0;
  assign io.io_Div_Divisor = div_active ? src2_q : '0;

  assign io.io_In_Ready  = in_ready_q;
  assign io.io_Out_Valid = out_valid_q;
  assign io.io_Out_Data  = result_q;
  assign io.io_Out_Rd    = rd_q;

`ifdef EXU_DIV_REUSE_EN
  logic            c_valid_q, c_word_q, c_signed_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q;

  assign reuse_hit = c_valid_q && (c_a_q == a_ext) && (c_b_q == b_ext) &&
                     (c_word_q == io.io_In_Word) && (c_signed_q == in_signed);
  assign reuse_res = io.io_In_Op[1] ? c_rem_q : c_quo_q;

  // Remember the last completed divider result; any flush forgets it.
  always_ff @(posedge clock) begin
    // NOTE: only the valid flag needs reset; the payload is never read while invalid.
    if (reset || io.io_Flush) begin
      c_valid_q <= 1'b0;
    end else if (state_q == S_WAIT && io.io_Div_OutValid) begin
      c_valid_q  <= 1'b1;
      c_a_q      <= src1_q;
      c_b_q      <= src2_q;
      c_word_q   <= word_q;
      c_signed_q <= signed_q;
      c_quo_q    <= extend(io.io_Div_Quotient, word_q, 1'b1);
      c_rem_q    <= extend(io.io_Div_Remainder, word_q, 1'b1);
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      word_q      <= 1'b0;
      signed_q    <= 1'b0;
      rem_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.io_In_Valid && !io.io_Flush) begin
            rd_q       <= io.io_In_Rd;
            rem_q      <= io.io_In_Op[1];
            word_q     <= io.io_In_Word;
            signed_q   <= in_signed;
            src1_q     <= a_ext;
            src2_q     <= b_ext;
            in_ready_q <= 1'b0;
            if (special || reuse_hit) begin
              result_q    <= special ? extend(special_res, io.io_In_Word, 1'b1) : reuse_res;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (io.io_Flush) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
          end else if (io.io_Div_Ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (io.io_Flush) begin
            state_q <= S_DRAIN;
          end else if (io.io_Div_OutValid) begin
            result_q    <= div_res;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (io.io_Div_Ready) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (io.io_Flush || io.io_Out_Ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_div_ctrl.sv
// tb_exu_div_ctrl: directed bench for exu_div_ctrl. It contains a
// behavioural divider, a cycle-level expectation model and literal checks
// taken from hand calculations.
module tb_exu_div_ctrl;
  localparam int XLEN = 64;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  exu_div_ctrl_if #(.XLEN(XLEN)) io ();
  exu_div_ctrl #(.XLEN(XLEN)) dut (.clock(clock), .reset(reset), .io(io));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic (RISC-V semantics) ----------------
  function automatic logic [63:0] ext_op(input logic [63:0] v, input logic w, input logic sgn);
    if (!w) return v;
    return sgn ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
  endfunction

  function automatic logic is_special(input logic [1:0] op, input logic w,
                                      input logic [63:0] s1, input logic [63:0] s2);
    logic [63:0] a, b;
    a = ext_op(s1, w, !op[0]);
    b = ext_op(s2, w, !op[0]);
    if (b == 64'd0) return 1'b1;
    return !op[0] && (b == '1) && (a == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  endfunction

  function automatic logic [63:0] model_res(input logic [1:0] op, input logic w,
                                            input logic [63:0] s1, input logic [63:0] s2);
    logic [63:0] a, b, q, r, res;
    logic signed [63:0] sa, sb;
    a = ext_op(s1, w, !op[0]);
    b = ext_op(s2, w, !op[0]);
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (is_special(op, w, s1, s2)) begin
      q = a; r = 64'd0;
    end else if (!op[0]) begin
      sa = a; sb = b; q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    res = op[1] ? r : q;
    return w ? {{32{res[31]}}, res[31:0]} : res;
  endfunction

  // ---------------- behavioural iterative divider ----------------
  initial begin
    logic busy, hs, fl, ov, nxt_ov, nxt_rdy, cw;
    int cnt;
    logic [63:0] ca, cb, nq, nr;
    logic [1:0] cs;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa64, sb64;
    logic [31:0] q32, r32;
    busy = 0; cnt = 0; ca = 0; cb = 0; cw = 0; cs = 0; nq = 0; nr = 0;
    io.io_Div_Ready = 1'b1; io.io_Div_OutValid = 1'b0;
    io.io_Div_Quotient = '0; io.io_Div_Remainder = '0;
    forever begin
      @(negedge clock);
      hs = io.io_Div_Valid && io.io_Div_Ready;
      fl = io.io_Div_Flush;
      ov = io.io_Div_OutValid;
      nxt_ov = 1'b0;
      nxt_rdy = io.io_Div_Ready;
      if (busy && !reset) begin
        check("div_dividend_stable", io.io_Div_Divdend, ca);
        check("div_divisor_stable", io.io_Div_Divisor, cb);
        check("div_mode_stable", {61'd0, io.io_Div_Divw, io.io_Div_Signed}, {61'd0, cw, cs});
      end
      if (reset || fl) begin
        busy = 0; nxt_rdy = 1'b1;
      end else if (hs) begin
        busy = 1; nxt_rdy = 1'b0;
        ca = io.io_Div_Divdend; cb = io.io_Div_Divisor;
        cw = io.io_Div_Divw; cs = io.io_Div_Signed;
        cnt = cw ? 32 : 64;
      end else if (busy) begin
        if (ov) begin
          busy = 0; nxt_rdy = 1'b1;
        end else begin
          cnt--;
          if (cnt == 0) begin
            nxt_ov = 1'b1;
            if (cw) begin
              if (cb[31:0] == 32'd0) begin
                q32 = '1; r32 = ca[31:0];
              end else if (cs[0]) begin
                sa32 = ca[31:0]; sb32 = cb[31:0]; q32 = sa32 / sb32; r32 = sa32 % sb32;
              end else begin
                q32 = ca[31:0] / cb[31:0]; r32 = ca[31:0] % cb[31:0];
              end
              nq = {32'd0, q32}; nr = {32'd0, r32};
            end else if (cb == 64'd0) begin
              nq = '1; nr = ca;
            end else if (cs[0]) begin
              sa64 = ca; sb64 = cb; nq = sa64 / sb64; nr = sa64 % sb64;
            end else begin
              nq = ca / cb; nr = ca % cb;
            end
          end
        end
      end
      @(posedge clock);
      #1;
      io.io_Div_Ready    = nxt_rdy;
      io.io_Div_OutValid = nxt_ov;
      if (nxt_ov) begin
        io.io_Div_Quotient  = nq;
        io.io_Div_Remainder = nr;
      end
    end
  end

  // ---------------- expectation model + per-cycle compare ----------------
  int          cyc = 0;
  bit          m_busy = 0;
  bit          m_nodiv = 0;
  int          m_from = 0;
  int          m_skip_ir = -1;
  logic [63:0] m_data = '0;
  logic [4:0]  m_rd = '0;
  bit          c_v = 0, p_w = 0, p_s = 0, c_w = 0, c_s = 0;
  logic [63:0] p_a = '0, p_b = '0, c_a = '0, c_b = '0;

  always @(negedge clock) begin
    bit exp_ov, hit, sgn;
    logic [63:0] a, b;
    cyc++;
    if (reset) begin
      m_busy = 0;
      c_v = 0;
    end else begin
      exp_ov = m_busy && (cyc >= m_from);
      check("out_valid", {63'd0, io.io_Out_Valid}, {63'd0, exp_ov});
      if (cyc != m_skip_ir)
        check("in_ready", {63'd0, io.io_In_Ready}, {63'd0, !m_busy});
      if (exp_ov) begin
        check("out_data", io.io_Out_Data, m_data);
        check("out_rd", {59'd0, io.io_Out_Rd}, {59'd0, m_rd});
      end
      if (m_busy && m_nodiv)
        check("no_div_valid", {63'd0, io.io_Div_Valid}, 64'd0);
      if (exp_ov && !m_nodiv && cyc == m_from) begin
        c_v = 1; c_a = p_a; c_b = p_b; c_w = p_w; c_s = p_s;
      end
      if (io.io_Flush) begin
        m_busy = 0;
        c_v = 0;
        m_skip_ir = cyc + 1;
      end else if (exp_ov && io.io_Out_Ready) begin
        m_busy = 0;
      end else if (!m_busy && io.io_In_Valid) begin
        sgn = !io.io_In_Op[0];
        a = ext_op(io.io_In_Src1, io.io_In_Word, sgn);
        b = ext_op(io.io_In_Src2, io.io_In_Word, sgn);
        hit = 0;
`ifdef EXU_DIV_REUSE_EN
        hit = c_v && c_a == a && c_b == b && c_w == io.io_In_Word && c_s == sgn;
`endif
        m_busy  = 1;
        m_data  = model_res(io.io_In_Op, io.io_In_Word, io.io_In_Src1, io.io_In_Src2);
        m_rd    = io.io_In_Rd;
        m_nodiv = is_special(io.io_In_Op, io.io_In_Word, io.io_In_Src1, io.io_In_Src2) || hit;
        m_from  = cyc + (m_nodiv ? 1 : (io.io_In_Word ? 35 : 67));
        p_a = a; p_b = b; p_w = io.io_In_Word; p_s = sgn;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] s1,
                       input logic [63:0] s2, input logic [4:0] rd);
    bit ok;
    ok = 0;
    @(posedge clock); #1;
    io.io_In_Valid = 1'b1; io.io_In_Op = op; io.io_In_Word = w;
    io.io_In_Src1 = s1; io.io_In_Src2 = s2; io.io_In_Rd = rd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (io.io_In_Ready) begin ok = 1; break; end
    end
    check("accept_seen", {63'd0, ok}, 64'd1);
    @(posedge clock); #1;
    io.io_In_Valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [63:0] lit);
    bit got;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (io.io_Out_Valid) begin got = 1; break; end
    end
    check({name, "_arrived"}, {63'd0, got}, 64'd1);
    if (got) check(name, io.io_Out_Data, lit);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic w,
                     input logic [63:0] s1, input logic [63:0] s2,
                     input logic [4:0] rd, input logic [63:0] lit);
    issue(op, w, s1, s2, rd);
    wait_out(name, lit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen, ir;
    int nvalid;
    reset = 1'b1;
    io.io_In_Valid = 0; io.io_In_Op = 0; io.io_In_Word = 0;
    io.io_In_Src1 = 0; io.io_In_Src2 = 0; io.io_In_Rd = 0;
    io.io_Flush = 0; io.io_Out_Ready = 1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", {63'd0, io.io_In_Ready}, 64'd1);
    check("rst_out_valid", {63'd0, io.io_Out_Valid}, 64'd0);
    check("rst_out_data", io.io_Out_Data, 64'd0);
    check("rst_out_rd", {59'd0, io.io_Out_Rd}, 64'd0);
    check("rst_div_ctrl", {60'd0, io.io_Div_Valid, io.io_Div_Flush, io.io_Div_Signed}, 64'd0);
    check("rst_div_opnd", io.io_Div_Divdend | io.io_Div_Divisor, 64'd0);

    run("divu_100_7", DIVU, 0, 64'd100, 64'd7, 5'd1, 64'd14);
    run("remu_100_7", REMU, 0, 64'd100, 64'd7, 5'd2, 64'd2);
    run("div_m7_2", DIV, 0, -64'sd7, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    run("rem_m7_2", REM, 0, -64'sd7, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    run("divw_m7_2", DIV, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFD);
    run("remw_m7_2", REM, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    run("divuw_ffffffff_1", DIVU, 1, 64'h1234_5678_FFFF_FFFF, 64'd1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    run("div_by_zero", DIV, 0, 64'd123, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    run("remu_by_zero", REMU, 0, 64'd55, 64'd0, 5'd9, 64'd55);
    run("remw_ovf", REM, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd10, 64'd0);
    run("divw_ovf", DIV, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd11,
        64'hFFFF_FFFF_8000_0000);
    run("div_ovf64", DIV, 0, 64'h8000_0000_0000_0000, '1, 5'd12, 64'h8000_0000_0000_0000);

    // Flush ten cycles into a divider operation.
    issue(DIVU, 0, 64'd1000000, 64'd3, 5'd13);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (io.io_Div_Valid) begin seen = 1; break; end
    end
    check("flush_div_valid_seen", {63'd0, seen}, 64'd1);
    repeat (10) @(posedge clock);
    #1 io.io_Flush = 1'b1;
    @(negedge clock);
    check("flush_div_flush", {63'd0, io.io_Div_Flush}, 64'd1);
    @(posedge clock); #1 io.io_Flush = 1'b0;
    ir = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (io.io_In_Ready) ir = 1;
    end
    check("flush_in_ready_2cyc", {63'd0, ir}, 64'd1);
    nvalid = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      if (io.io_Out_Valid) nvalid++;
    end
    check("flush_no_out_valid", nvalid, 64'd0);
    run("divu_9_3", DIVU, 0, 64'd9, 64'd3, 5'd14, 64'd3);

    // Flush in the same cycle as an accept kills it.
    @(posedge clock); #1;
    io.io_In_Valid = 1'b1; io.io_In_Op = DIV; io.io_In_Word = 0;
    io.io_In_Src1 = 64'd5; io.io_In_Src2 = 64'd0; io.io_In_Rd = 5'd15;
    io.io_Flush = 1'b1;
    @(posedge clock); #1;
    io.io_In_Valid = 1'b0; io.io_Flush = 1'b0;
    @(negedge clock);
    check("flush_accept_out_valid", {63'd0, io.io_Out_Valid}, 64'd0);
    check("flush_accept_in_ready", {63'd0, io.io_In_Ready}, 64'd1);

    // Writeback back-pressure: result held in DONE.
    @(posedge clock); #1 io.io_Out_Ready = 1'b0;
    run("hold_result", DIVU, 0, 64'd1000, 64'd10, 5'd9, 64'd100);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      check("hold_data", io.io_Out_Data, 64'd100);
      check("hold_rd", {59'd0, io.io_Out_Rd}, 64'd9);
      check("hold_in_ready", {63'd0, io.io_In_Ready}, 64'd0);
    end
    @(posedge clock); #1 io.io_Out_Ready = 1'b1;
    @(negedge clock);
    check("hold_release_valid", {63'd0, io.io_Out_Valid}, 64'd1);
    @(negedge clock);
    check("hold_idle_after", {63'd0, io.io_In_Ready}, 64'd1);

    // Result reuse sequence (timing predicted by the model for either build).
    run("reuse_div", DIV, 0, 64'd100, 64'd7, 5'd16, 64'd14);
    run("reuse_rem", REM, 0, 64'd100, 64'd7, 5'd17, 64'd2);
    @(posedge clock); #1 io.io_Flush = 1'b1;
    @(posedge clock); #1 io.io_Flush = 1'b0;
    run("reuse_rem_after_flush", REM, 0, 64'd100, 64'd7, 5'd18, 64'd2);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exu_div_ctrl.md
# exu_div_ctrl

Execute-stage front end for the iterative 64-bit divider. It accepts RISC-V DIV/DIVU/REM/REMU (and W forms) from the EXU issue logic and resolves divide-by-zero and signed overflow locally. All other operations are driven to the divider under its Valid/Ready/OutValid protocol, with operands held stable for the whole operation. The selected result is returned sign-corrected, with W results sign-extended, through a valid/ready writeback port.

## Interface
- XLEN, 64: datapath width; only 64 is supported.
- clock  in  1  system clock
- reset  in  1  reset is synchronous and active-high
- io_In_Valid  in  1  request valid
- io_In_Ready  out  1  request accepted when both Valid and Ready are high
- io_In_Op  in  2  op[0]=unsigned, op[1]=remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU)
- io_In_Word  in  1  W-form (32-bit) operation
- io_In_Src1 / io_In_Src2  in  64  dividend / divisor
- io_In_Rd  in  5  destination tag, returned unchanged
- io_Flush  in  1  kill the in-flight operation
- io_Out_Valid  out  1  result valid
- io_Out_Ready  in  1  writeback accepts result
- io_Out_Data  out  64  result
- io_Out_Rd  out  5  tag
- io_Div_Valid, io_Div_Flush, io_Div_Divw  out  1  divider control
- io_Div_Signed  out  2  11=signed, 00=unsigned
- io_Div_Divdend, io_Div_Divisor  out  64  divider operands
- io_Div_Ready, io_Div_OutValid  in  1  divider idle / one-cycle result pulse
- io_Div_Quotient, io_Div_Remainder  in  64  divider results

## Operation
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- io_In_Ready = (state==IDLE).
- On accept, register op, word, rd and operands.
  - W operands are taken from src[31:0]: sign-extended for signed ops, zero-extended for unsigned ops.
- Special cases are evaluated on the extended operands at accept and load the result register directly, going IDLE→DONE. The divider is never touched.
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed, dividend==most-negative (64-bit, or 32-bit for W) and divisor==-1: quotient = dividend; remainder = 0.
- Otherwise go IDLE→REQ.
  - In REQ, io_Div_Valid = io_Div_Ready & !io_Flush. When it fires, go to WAIT.
  - In WAIT, on io_Div_OutValid, capture Quotient or Remainder per op[1] and go to DONE.
  - W results: captured value[31:0] sign-extended to 64 bits. The divider returns zero-extended W results.
- io_Div_Divw, io_Div_Signed and operands are driven from registers in REQ and WAIT and must not change until the cycle after OutValid. The divider reads them combinationally for its whole operation. They are zero in all other states.
- DONE: io_Out_Valid=1 with Data/Rd held stable. Go to IDLE when io_Out_Ready=1.
- Flush:
  - IDLE, REQ, DONE: go to IDLE next cycle; any result is dropped.
  - WAIT: io_Div_Flush=1 that cycle, then go to DRAIN.
  - DRAIN: io_Div_Flush=1 until io_Div_Ready=1, then go to IDLE.
  - An io_Div_OutValid arriving in the flush cycle is discarded.
  - A flush in the same cycle as an accept kills that accept: state stays IDLE.
- Reset: state IDLE. All outputs 0 except io_In_Ready=1.

## Timing
- Divider handshake fires at cycle T: OutValid at T+65 (64-bit) or T+33 (W).
- Accept at t: io_Div_Valid at t+1 if the divider is ready.
- io_Out_Valid asserts the cycle after io_Div_OutValid: t+67 (64-bit) or t+35 (W).
- Special case: accept at t, io_Out_Valid at t+1.
- Back-to-back: the next accept is possible the cycle after Out handshake.
- Flush in WAIT: io_In_Ready returns within 2 cycles.

## Configuration
- EXU_DIV_REUSE_EN defined:
  - Keep the last completed non-special divider result (quotient and remainder, both post-correction) with its Src1, Src2, Word and signedness; the entry is marked valid when it is captured.
  - A request matching all of these fields completes IDLE→DONE (Out_Valid at t+1) with the stored quotient or remainder per op[1].
  - Flush or reset invalidates the entry.
- Not defined: no storage; every non-special op uses the divider.

## Test plan
- DIVU 100/7 -> Out_Data 14 at t+67. REMU 100/7 -> 2.
- Signed ops:
  - DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD.
  - REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
  - DIVW 0x0000_0000_FFFF_FFF9 / 2 -> 0xFFFF_FFFF_FFFF_FFFD at t+35.
- Special cases:
  - DIV x/0 -> all ones at t+1, io_Div_Valid never asserted.
  - REMW 0x8000_0000/-1 -> 0.
  - DIVW 0x8000_0000/-1 -> 0xFFFF_FFFF_8000_0000.
- Flush 10 cycles after io_Div_Valid -> io_Div_Flush pulse, no io_Out_Valid, io_In_Ready high within 2 cycles. The next DIVU 9/3 -> 3.
- Hold io_Out_Ready=0 for 5 cycles in DONE -> Data/Rd stable, io_In_Ready=0. Ready -> IDLE next cycle.
- EXU_DIV_REUSE_EN: DIV 100/7 then REM 100/7 -> 14, then 2 at t+1 with no io_Div_Valid. After a flush, the same REM uses the divider again.
